// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed, XOR-checksummed byte frame and writes it as
// little-endian 32-bit words into instruction memory, holding the core in reset until the load succeeds.
`default_nettype none

module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        imem_we,
  output logic        core_rst_n,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_CSUM  = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] word_q, word_d;
  logic        rx_ready_q, rx_ready_d;
  logic        imem_we_q, imem_we_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] imem_wdata_q, imem_wdata_d;
  logic        core_rst_n_q, core_rst_n_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        accept;
  logic [15:0] len_full;

  assign accept   = rx_valid & rx_ready_q;
  assign len_full = {rx_data, len_q[7:0]};

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    byte_cnt_d   = byte_cnt_q;
    csum_d       = csum_q;
    word_d       = word_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN0;
          word_idx_d = 16'd0;
          byte_cnt_d = 16'd0;
          csum_d     = 8'd0;
          word_d     = 32'd0;
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          csum_d     = csum_q ^ rx_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d[15:8] = rx_data;
          csum_d      = csum_q ^ rx_data;
          if ({1'b0, len_full} > DEPTH_LIM) begin
            state_d = S_ERR;
          end else if (len_full == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d = csum_q ^ rx_data;
          word_d[{byte_cnt_q[1:0], 3'b000} +: 8] = rx_data;
          if (byte_cnt_q == 16'd3) begin
            // Latch the write beat now so address/data are registered during WRITE.
            byte_cnt_d   = 16'd0;
            state_d      = S_WRITE;
            imem_addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
            imem_wdata_d = word_d;
          end else begin
            byte_cnt_d = byte_cnt_q + 16'd1;
          end
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
        state_d    = (word_idx_q == len_q - 16'd1) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rx_ready_d   = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                   (state_d == S_DATA) || (state_d == S_CSUM);
    imem_we_d    = (state_d == S_WRITE);
    core_rst_n_d = (state_d == S_DONE);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      len_q        <= 16'd0;
      word_idx_q   <= 16'd0;
      byte_cnt_q   <= 16'd0;
      csum_q       <= 8'd0;
      word_q       <= 32'd0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= 32'd0;
      imem_wdata_q <= 32'd0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      csum_q       <= csum_d;
      word_q       <= word_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frame table, hand-written corner sequences and random frames
// checked against a frame-level reference model; two instances cover BASE_ADDR 0 and 0x100.
`default_nettype none

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  logic        rx_ready0, rx_ready1, we0, we1, crn0, crn1, done0, done1, err0, err1;
  logic [31:0] addr0, addr1, wd0, wd1;

  always #5 clk = ~clk;

  imem_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(256)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready0), .imem_addr(addr0), .imem_wdata(wd0), .imem_we(we0),
    .core_rst_n(crn0), .done(done0), .error(err0)
  );

  imem_loader #(.BASE_ADDR(32'h0000_0100), .DEPTH_WORDS(256)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready1), .imem_addr(addr1), .imem_wdata(wd1), .imem_we(we1),
    .core_rst_n(crn1), .done(done1), .error(err1)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] wr0[$];
  logic [63:0] wr1[$];
  logic [31:0] exp_w[$];
  logic [7:0]  frame_q[$];
  int          long_pulse = 0;
  logic        we0_prev = 1'b0;
  logic        we1_prev = 1'b0;

  // Write monitor: imem_we is registered, so one sample per cycle on the falling edge.
  always @(negedge clk) begin
    if (we0) wr0.push_back({addr0, wd0});
    if (we1) wr1.push_back({addr1, wd1});
    if ((we0 && we0_prev) || (we1 && we1_prev)) long_pulse++;
    we0_prev <= we0;
    we1_prev <= we1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget = 200;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      total++;
      bad++;
      $display("FAIL send_byte timeout: rx_ready stayed %b, required 1", rx_ready0);
    end else begin
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input bit gaps);
    wr0.delete();
    wr1.delete();
    pulse_start();
    foreach (frame_q[i]) send_byte(frame_q[i], gaps);
    repeat (3) @(negedge clk);
  endtask

  // Reference: words are 4-byte little-endian groups of the payload, written at base+4k;
  // oversize length rejects before any payload; XOR of everything before the checksum must match.
  task automatic model_expect(output bit ed, output bit ee);
    int n;
    logic [7:0] x;
    exp_w.delete();
    n = int'({frame_q[1], frame_q[0]});
    if (n > 256) begin
      ed = 1'b0;
      ee = 1'b1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < 4 * n + 2; i++) x ^= frame_q[i];
    for (int k = 0; k < n; k++)
      exp_w.push_back({frame_q[4*k+5], frame_q[4*k+4], frame_q[4*k+3], frame_q[4*k+2]});
    ed = (x == frame_q[4*n+2]);
    ee = !ed;
  endtask

  task automatic cmp_result(input string nm, input bit ed, input bit ee);
    chk({nm, ".done0"}, 32'(done0), 32'(ed));
    chk({nm, ".done1"}, 32'(done1), 32'(ed));
    chk({nm, ".error0"}, 32'(err0), 32'(ee));
    chk({nm, ".error1"}, 32'(err1), 32'(ee));
    chk({nm, ".core_rst_n0"}, 32'(crn0), 32'(ed));
    chk({nm, ".core_rst_n1"}, 32'(crn1), 32'(ed));
    chk({nm, ".rx_ready"}, 32'(rx_ready0), 32'd0);
    chk({nm, ".nwrites0"}, 32'(wr0.size()), 32'(exp_w.size()));
    chk({nm, ".nwrites1"}, 32'(wr1.size()), 32'(exp_w.size()));
    for (int k = 0; k < exp_w.size(); k++) begin
      if (k < wr0.size()) begin
        chk({nm, ".addr0"}, wr0[k][63:32], 32'(4 * k));
        chk({nm, ".data0"}, wr0[k][31:0], exp_w[k]);
      end
      if (k < wr1.size()) begin
        chk({nm, ".addr1"}, wr1[k][63:32], 32'h100 + 32'(4 * k));
        chk({nm, ".data1"}, wr1[k][31:0], exp_w[k]);
      end
    end
    chk({nm, ".we_width"}, 32'(long_pulse), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ".rx_ready"}, 32'(rx_ready0), 32'd0);
    chk({nm, ".we"}, 32'(we0), 32'd0);
    chk({nm, ".addr0"}, addr0, 32'd0);
    chk({nm, ".addr1"}, addr1, 32'd0);
    chk({nm, ".wdata"}, wd0, 32'd0);
    chk({nm, ".core_rst_n"}, 32'(crn0), 32'd0);
    chk({nm, ".done"}, 32'(done0), 32'd0);
    chk({nm, ".error"}, 32'(err0), 32'd0);
  endtask

  typedef struct {
    string             nm;
    int                nb;
    logic [15:0][7:0]  b;
    bit                gaps;
    bit                ed;
    bit                ee;
    int                nw;
    logic [31:0]       w0;
    logic [31:0]       w1;
  } vec_t;

  vec_t vt[6];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ed, ee;
    logic [15:0] n16;
    logic [7:0]  cs;
    int          nn;

    vt[0] = '{"single", 7, {72'h0, 8'h12, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h01},
              1'b0, 1'b1, 1'b0, 1, 32'h0000_0013, 32'h0};
    vt[1] = '{"badcsum", 7, {72'h0, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h01},
              1'b0, 1'b0, 1'b1, 1, 32'h0000_0013, 32'h0};
    vt[2] = '{"zero_len", 3, {104'h0, 8'h00, 8'h00, 8'h00},
              1'b0, 1'b1, 1'b0, 0, 32'h0, 32'h0};
    vt[3] = '{"oversize", 2, {112'h0, 8'h01, 8'h01},
              1'b0, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vt[4] = '{"two_words", 11, {40'h0, 8'h8A, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33,
                                8'h22, 8'h11, 8'h00, 8'h02},
              1'b1, 1'b1, 1'b0, 2, 32'h4433_2211, 32'h8877_6655};
    vt[5] = '{"zero_len_bad", 3, {104'h0, 8'h01, 8'h00, 8'h00},
              1'b0, 1'b0, 1'b1, 0, 32'h0, 32'h0};

    // Reset with inputs active: everything must be ignored.
    rst = 1'b0; start = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
    chk("reset.idle_ready", 32'(rx_ready0), 32'd0);

    for (int v = 0; v < 6; v++) begin
      frame_q.delete();
      for (int i = 0; i < vt[v].nb; i++) frame_q.push_back(vt[v].b[i]);
      exp_w.delete();
      if (vt[v].nw > 0) exp_w.push_back(vt[v].w0);
      if (vt[v].nw > 1) exp_w.push_back(vt[v].w1);
      run_frame(vt[v].gaps);
      cmp_result(vt[v].nm, vt[v].ed, vt[v].ee);
    end

    // Restart from DONE clears done/core_rst_n on the very next edge.
    frame_q = '{8'h00, 8'h00, 8'h00};
    exp_w.delete();
    run_frame(1'b0);
    cmp_result("restart_pre", 1'b1, 1'b0);
    pulse_start();
    chk("restart.done", 32'(done0), 32'd0);
    chk("restart.core_rst_n", 32'(crn0), 32'd0);
    chk("restart.rx_ready", 32'(rx_ready0), 32'd1);
    foreach (frame_q[i]) send_byte(frame_q[i], 1'b0);
    repeat (2) @(negedge clk);
    chk("restart.done_again", 32'(done0), 32'd1);

    // start pulsed in the middle of DATA must be ignored.
    wr0.delete(); wr1.delete();
    pulse_start();
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
    pulse_start();
    send_byte(8'hCC, 1'b0); send_byte(8'hDD, 1'b0); send_byte(8'h01, 1'b0);
    repeat (3) @(negedge clk);
    exp_w = '{32'hDDCC_BBAA};
    cmp_result("start_ignored", 1'b1, 1'b0);

    // Reset after the 2nd payload byte aborts the session.
    wr0.delete(); wr1.delete();
    pulse_start();
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
    rst = 1'b0; start = 1'b1; rx_valid = 1'b1; rx_data = 8'hCC;
    @(negedge clk);
    chk_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    rx_data = 8'hDD;
    repeat (4) @(negedge clk);
    rx_valid = 1'b0;
    chk("midreset.idle_ready", 32'(rx_ready0), 32'd0);
    chk("midreset.no_write", 32'(wr0.size()), 32'd0);
    frame_q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    model_expect(ed, ee);
    run_frame(1'b1);
    cmp_result("after_reset", ed, ee);

    // Largest accepted frame: exactly DEPTH_WORDS words.
    frame_q.delete();
    frame_q.push_back(8'h00); frame_q.push_back(8'h01);
    cs = 8'h01;
    for (int i = 0; i < 1024; i++) begin
      frame_q.push_back(8'($urandom));
      cs ^= frame_q[frame_q.size() - 1];
    end
    frame_q.push_back(cs);
    model_expect(ed, ee);
    run_frame(1'b0);
    cmp_result("full_depth", ed, ee);

    // Random frames: random lengths, gaps, occasional oversize or corrupted checksum.
    for (int r = 0; r < 24; r++) begin
      int mode;
      mode = $urandom_range(0, 9);
      frame_q.delete();
      if (mode == 0) nn = 257 + $urandom_range(0, 2000);
      else           nn = $urandom_range(0, 5);
      n16 = 16'(nn);
      frame_q.push_back(n16[7:0]);
      frame_q.push_back(n16[15:8]);
      if (mode != 0) begin
        cs = n16[7:0] ^ n16[15:8];
        for (int i = 0; i < 4 * nn; i++) begin
          frame_q.push_back(8'($urandom));
          cs ^= frame_q[frame_q.size() - 1];
        end
        if (mode == 1) cs ^= 8'($urandom_range(1, 255));
        frame_q.push_back(cs);
      end
      model_expect(ed, ee);
      run_frame(1'b1);
      cmp_result($sformatf("rand%0d", r), ed, ee);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of the first loaded word.
REQ-002 The module SHALL have parameter DEPTH_WORDS, default 256: the maximum number of words accepted.
REQ-003 The module SHALL have port clk, input, 1 bit: clock, all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 The module SHALL have port start, input, 1 bit: begin a load session.
REQ-006 The module SHALL have port rx_data, input, 8 bits: incoming byte stream.
REQ-007 The module SHALL have port rx_valid, input, 1 bit: rx_data is valid.
REQ-008 The module SHALL have port rx_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 The module SHALL have port imem_addr, output, 32 bits: instruction memory write address.
REQ-010 The module SHALL have port imem_wdata, output, 32 bits: instruction memory write data.
REQ-011 The module SHALL have port imem_we, output, 1 bit: instruction memory write enable.
REQ-012 The module SHALL have port core_rst_n, output, 1 bit: active-low core hold, driven to the core's rst.
REQ-013 The module SHALL have port done, output, 1 bit: load completed with a good checksum.
REQ-014 The module SHALL have port error, output, 1 bit: load rejected.

Function
REQ-015 Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N payload bytes, then 1 checksum byte.
REQ-016 A byte SHALL be accepted only on a rising edge where rx_valid=1 and rx_ready=1; rx_data is ignored otherwise.
REQ-017 FSM states: IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR.
REQ-018 IDLE -> LEN0 on start=1; DONE or ERR -> LEN0 on start=1; start SHALL be ignored in every other state.
REQ-019 rx_ready SHALL be 1 exactly in LEN0, LEN1, DATA and CSUM, and 0 in IDLE, WRITE, DONE and ERR.
REQ-020 On acceptance of LEN_HI: if N > DEPTH_WORDS -> ERR with no write issued; if N = 0 -> CSUM; otherwise -> DATA.
REQ-021 In DATA, bytes SHALL pack little-endian: the 1st byte of a word goes to [7:0] and the 4th byte to [31:24].
REQ-022 Acceptance of the 4th byte of a word SHALL move the FSM to WRITE on the next cycle.
REQ-023 WRITE lasts exactly 1 cycle with imem_we=1, imem_wdata=the assembled word, and imem_addr=BASE_ADDR + 4*k, where k is the 0-based word index; WRITE then goes to DATA, or to CSUM after word N-1.
REQ-024 imem_we SHALL be 0 in every state other than WRITE; imem_addr and imem_wdata hold their last value outside WRITE.
REQ-025 Checksum = 8-bit XOR of every accepted byte from LEN_LO through the last payload byte.
REQ-026 A checksum byte that matches SHALL move the FSM to DONE; a mismatch SHALL move it to ERR.
REQ-027 Words already written before ERR SHALL NOT be retracted.
REQ-028 core_rst_n SHALL be 1 only in DONE and 0 in every other state, so the core is held in reset through any load or error.
REQ-029 done=1 only in DONE and error=1 only in ERR; both are registered, and both clear on the cycle the FSM enters LEN0.
REQ-030 Starting a new session SHALL clear the word index, the byte counter and the checksum.
REQ-031 rx_valid stalls of any length in LEN0, LEN1, DATA or CSUM SHALL hold all state unchanged.
REQ-032 The word index and the byte counter SHALL be 16 bits wide, and the byte counter SHALL NOT wrap before N words are written.

Reset
REQ-033 When rst=0 at a rising edge: state=IDLE, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, done=0, error=0, and the counters and checksum cleared.
REQ-034 rst=0 mid-session SHALL abort the load in the same edge; no further writes occur, and the module waits in IDLE for start.
REQ-035 While rst=0, all inputs SHALL be ignored.

Verification
REQ-036 Single word: start; bytes 01 00 13 00 00 00 12 -> one imem_we pulse with addr 0x0, wdata 0x00000013; then done=1, core_rst_n=1.
REQ-037 Two words with BASE_ADDR=0x100 and random rx_valid gaps -> writes to 0x100 and 0x104, each imem_we exactly 1 cycle, correct little-endian data.
REQ-038 Bad checksum: N=1 frame with checksum 0x13 -> one write issued, then error=1, done=0, core_rst_n=0.
REQ-039 Oversize: LEN 0x0101 with DEPTH_WORDS=256 -> ERR right after LEN_HI, zero writes, rx_ready=0.
REQ-040 N=0: bytes 00 00 00 -> done=1 with no writes; then start again from DONE -> done=0 and core_rst_n=0 the next cycle.
REQ-041 rst=0 asserted after the 2nd payload byte -> all outputs take their reset values, no imem_we afterwards, and a following full load succeeds.
